// File: rtl/key_debounce_multi_pkg.sv
// Shared types and helpers for the multi-key debouncer.
package key_pkg;

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_t;

   localparam int CLK_HZ = 27_000_000;

   function automatic int ms_to_cycles(input int ms);
      return ms * (CLK_HZ / 1000);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: synchroniser, debounce/repeat FSM and shared counter; outputs registered.
// Press/release land SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks after a stable raw edge; no backpressure.
module key_debounce_channel
   import key_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int ACTIVE_LOW      = 0,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 13500000,
   parameter int REPEAT_PERIOD   = 2700000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic INACT  = (ACTIVE_LOW != 0);
   localparam logic REP_ON = (REPEAT_EN != 0);

   logic [SYNC_STAGES-1:0] sync_q;
   key_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   first_q, first_d;
   logic                   level_q, level_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   repeat_q, repeat_d;
   logic                   s, deb_done, rep_hit;

   // s = 1 means pressed regardless of pin polarity
   assign s        = sync_q[SYNC_STAGES-1] ^ INACT;
   assign deb_done = (cnt_q == DEB_LAST);
   assign rep_hit  = (cnt_q == (first_q ? DLY_LAST : PER_LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= {SYNC_STAGES{INACT}};
         state_q   <= IDLE;
         cnt_q     <= '0;
         first_q   <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], key_i};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         first_q   <= first_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      case (state_q)
         IDLE: begin
            if (s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (deb_done) begin
               state_d = PRESSED;
               cnt_d   = '0;
               first_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else if (REP_ON) begin
               if (rep_hit) begin
                  cnt_d   = '0;
                  first_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         RELEASE_WAIT: begin
            // Returning to PRESSED keeps first, so the current repeat interval restarts
            if (s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (deb_done) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         PRESS_WAIT: begin
            if (s && deb_done) begin
               level_d = 1'b1;
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            if (s && REP_ON && rep_hit) repeat_d = 1'b1;
         end
         RELEASE_WAIT: begin
            if (!s && deb_done) begin
               level_d   = 1'b0;
               release_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N independent debounced keys with press/release/repeat pulses and an any_press summary.
// Pulses registered, SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks after a stable raw edge; no backpressure.
module key_debounce_multi
   import key_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = ms_to_cycles(10),
   parameter int ACTIVE_LOW      = 0,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = ms_to_cycles(500),
   parameter int REPEAT_PERIOD   = ms_to_cycles(100)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat,
   output logic              any_press
);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_debounce_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW),
         .REPEAT_EN      (REPEAT_EN),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .key_i    (key[g]),
         .level_o  (key_level[g]),
         .press_o  (key_press[g]),
         .release_o(key_release[g]),
         .repeat_o (key_repeat[g])
      );
   end

   assign any_press = |key_press;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench: directed test-plan scenarios plus random key traffic, checked against a run-length reference model.
module tb_key_debounce_multi;

   localparam int NK = 2;
   localparam int SS = 2;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [NK-1:0] key_a, key_b;
   logic [NK-1:0] lvl_a, prs_a, rel_a, rep_a;
   logic [NK-1:0] lvl_b, prs_b, rel_b, rep_b;
   logic          any_a, any_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_debounce_multi #(
      .N_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(0),
      .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut_a (
      .clk(clk), .rst(rst), .key(key_a), .key_level(lvl_a), .key_press(prs_a),
      .key_release(rel_a), .key_repeat(rep_a), .any_press(any_a)
   );

   key_debounce_multi #(
      .N_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1),
      .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut_b (
      .clk(clk), .rst(rst), .key(key_b), .key_level(lvl_b), .key_press(prs_b),
      .key_release(rel_b), .key_repeat(rep_b), .any_press(any_b)
   );

   // Reference: a level flips once the synchronised input has disagreed with it
   // on DB+1 consecutive edges; repeats count held edges since the interval start.
   bit            m_pipe [2][NK][SS];
   bit            m_lvl  [2][NK];
   bit            m_first[2][NK];
   int            m_run  [2][NK];
   int            m_since[2][NK];
   logic [NK-1:0] e_lvl[2], e_prs[2], e_rel[2], e_rep[2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < SS; i++) m_pipe[d][k][i] = 1'b0;
            m_lvl[d][k]   = 1'b0;
            m_first[d][k] = 1'b0;
            m_run[d][k]   = 0;
            m_since[d][k] = 0;
         end
         e_lvl[d] = '0; e_prs[d] = '0; e_rel[d] = '0; e_rep[d] = '0;
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < NK; k++) begin
            bit p, s;
            p = (d == 0) ? key_a[k] : ~key_b[k];
            s = m_pipe[d][k][SS-1];
            for (int i = SS - 1; i > 0; i--) m_pipe[d][k][i] = m_pipe[d][k][i-1];
            m_pipe[d][k][0] = p;
            e_prs[d][k] = 1'b0; e_rel[d][k] = 1'b0; e_rep[d][k] = 1'b0;
            if (s != m_lvl[d][k]) begin
               if (m_run[d][k] == DB) begin
                  m_lvl[d][k] = s;
                  m_run[d][k] = 0;
                  if (s) begin
                     e_prs[d][k]   = 1'b1;
                     m_since[d][k] = 0;
                     m_first[d][k] = 1'b1;
                  end else begin
                     e_rel[d][k] = 1'b1;
                  end
               end else begin
                  m_run[d][k]++;
               end
            end else if (m_run[d][k] > 0) begin
               m_run[d][k]   = 0;
               m_since[d][k] = 0;
            end else if (m_lvl[d][k] && d == 0) begin
               m_since[d][k]++;
               if (m_since[d][k] == (m_first[d][k] ? RD : RP)) begin
                  e_rep[d][k]   = 1'b1;
                  m_since[d][k] = 0;
                  m_first[d][k] = 1'b0;
               end
            end
            e_lvl[d][k] = m_lvl[d][k];
         end
      end
   endtask

   task automatic check(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   task automatic check_all();
      check("level",   0, 8'(lvl_a), 8'(e_lvl[0]));
      check("press",   0, 8'(prs_a), 8'(e_prs[0]));
      check("release", 0, 8'(rel_a), 8'(e_rel[0]));
      check("repeat",  0, 8'(rep_a), 8'(e_rep[0]));
      check("any",     0, 8'(any_a), 8'(|e_prs[0]));
      check("level",   1, 8'(lvl_b), 8'(e_lvl[1]));
      check("press",   1, 8'(prs_b), 8'(e_prs[1]));
      check("release", 1, 8'(rel_b), 8'(e_rel[1]));
      check("repeat",  1, 8'(rep_b), 8'(e_rep[1]));
      check("any",     1, 8'(any_b), 8'(|e_prs[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic async_reset_pulse();
      #2 rst = 1'b1;
      model_reset();
      #1 check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int t_press, t_rel, n_rep, n_press, next_rep;
      int reps[$];

      // 1: reset with both keys held, then fresh press 7 clocks after release of reset
      rst = 1'b1; key_a = 2'b11; key_b = 2'b11;
      model_reset();
      #2 check_all();
      tick(); tick();
      rst = 1'b0;
      t_press = -1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (prs_a === 2'b11 && any_a === 1'b1 && t_press < 0) t_press = t;
      end
      check("s1_press_cycle", 0, 8'(t_press), 8'd7);
      key_a = 2'b00;
      repeat (15) tick();

      // 2: bounce on key 0 never reaches the debounce limit
      n_press = 0;
      foreach (reps[i]) reps.delete(i);
      for (int t = 0; t < 5; t++) begin
         key_a[0] = (t == 1 || t == 4) ? 1'b0 : 1'b1;
         tick();
         n_press += int'(prs_a[0]) + int'(lvl_a[0]);
      end
      key_a[0] = 1'b0;
      for (int t = 0; t < 12; t++) begin
         tick();
         n_press += int'(prs_a[0]) + int'(lvl_a[0]);
      end
      check("s2_no_press", 0, 8'(n_press), 8'd0);

      // 3: clean press, hold through repeats, release
      key_a[0] = 1'b1;
      t_press = -1; t_rel = -1;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (prs_a[0] === 1'b1) t_press = t;
         if (rel_a[0] === 1'b1) t_rel = t;
         if (rep_a[0] === 1'b1) reps.push_back(t);
         if (t == 24) key_a[0] = 1'b0;
      end
      check("s3_press", 0, 8'(t_press), 8'd7);
      check("s3_release", 0, 8'(t_rel), 8'd31);
      check("s3_rep_count_ge3", 0, 8'(reps.size() >= 3), 8'd1);
      if (reps.size() >= 3) begin
         check("s3_rep0", 0, 8'(reps[0]), 8'd17);
         check("s3_rep1", 0, 8'(reps[1]), 8'd20);
         check("s3_rep2", 0, 8'(reps[2]), 8'd23);
      end

      // 4: short release bounce after the first repeat restarts the period interval
      key_a[0] = 1'b1;
      t_rel = -1; next_rep = -1;
      for (int t = 1; t <= 30; t++) begin
         tick();
         if (t == 18) key_a[0] = 1'b0;
         if (t == 20) key_a[0] = 1'b1;
         if (rel_a[0] === 1'b1) t_rel = t;
         if (rep_a[0] === 1'b1 && t > 23 && next_rep < 0) next_rep = t;
      end
      check("s4_no_release", 0, 8'(t_rel == -1), 8'd1);
      check("s4_next_repeat", 0, 8'(next_rep), 8'd26);
      key_a[0] = 1'b0;
      repeat (15) tick();

      // 5: async reset mid press-wait, and mid hold
      key_a = 2'b01;
      repeat (4) tick();
      async_reset_pulse();
      key_a = 2'b00;
      repeat (20) tick();
      key_a = 2'b10;
      repeat (10) tick();
      async_reset_pulse();
      check("s5_level_after_rst", 0, 8'(lvl_a), 8'd0);
      key_a = 2'b00;
      repeat (20) tick();

      // 6: active-low instance, no auto-repeat
      key_b = 2'b01;
      t_press = -1; n_rep = 0;
      for (int t = 1; t <= 60; t++) begin
         tick();
         if (prs_b[1] === 1'b1) t_press = t;
         n_rep += int'(rep_b != 2'b00);
      end
      check("s6_press", 1, 8'(t_press), 8'd7);
      check("s6_no_repeat", 1, 8'(n_rep), 8'd0);
      key_b = 2'b11;
      repeat (15) tick();

      // Random traffic on both instances with occasional async resets
      for (int it = 0; it < 300; it++) begin
         key_a = NK'($urandom);
         key_b = NK'($urandom);
         repeat ($urandom_range(1, 25)) tick();
         if ($urandom_range(0, 39) == 0) async_reset_pulse();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Parametrised, multi-channel successor to the single-key debouncer, for the 27 MHz board clock. Each of N_KEYS raw push-button inputs is synchronised and debounced independently, with input polarity selected by parameter. Each channel produces a clean level, one-cycle press and release pulses, and an optional auto-repeat pulse train while the key is held. It sits between the board pins and the UI/control FSMs, and replaces per-key debouncer instances.

Parameters:
N_KEYS, 4, number of independent key channels (1..16)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 270000, consecutive stable synchronised samples needed to accept a change (10 ms at 27 MHz; >=1)
ACTIVE_LOW, 0, 1 = raw input reads 0 when the key is pressed
REPEAT_EN, 1, 0 = key_repeat tied to 0 and the repeat logic is removed
REPEAT_DELAY, 13500000, held cycles before the first repeat pulse (500 ms)
REPEAT_PERIOD, 2700000, cycles between subsequent repeat pulses (100 ms)

Ports:
clk  input  1  system clock, 27 MHz
rst  input  1  asynchronous reset, active-high
key  input  N_KEYS  raw asynchronous button inputs
key_level  output  N_KEYS  debounced level, 1 = pressed (after polarity correction)
key_press  output  N_KEYS  one-cycle pulse on an accepted press
key_release  output  N_KEYS  one-cycle pulse on an accepted release
key_repeat  output  N_KEYS  one-cycle pulse per auto-repeat tick while held
any_press  output  1  OR-reduction of key_press, same cycle

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. While rst=1, all state is cleared immediately, regardless of clk.
- Reset values: all outputs 0. All FSMs go to IDLE and all counters to 0. Synchroniser flops reset to the inactive raw level (0 if ACTIVE_LOW=0, 1 if ACTIVE_LOW=1), so no spurious press appears after reset.
- Polarity: s = synchroniser output XOR ACTIVE_LOW, so s=1 means pressed.
- Channel independence: each channel has its own SYNC_STAGES-flop synchroniser, 2-bit FSM and counter. The counter width is $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
- FSM state IDLE (level 0): if s=1, go to PRESS_WAIT and set cnt=0.
- FSM state PRESS_WAIT (level 0):
  - If s=0, return to IDLE and set cnt=0 (bounce rejected, no pulse).
  - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, set key_level<=1, pulse key_press for 1 cycle, set cnt=0 and first=1.
  - Else increment cnt.
- FSM state PRESSED (level 1):
  - If s=0, go to RELEASE_WAIT and set cnt=0.
  - Else, when REPEAT_EN=1: if cnt==(first ? REPEAT_DELAY : REPEAT_PERIOD)-1, pulse key_repeat, set cnt=0 and first=0. Otherwise increment cnt.
- FSM state RELEASE_WAIT (level 1):
  - If s=1, return to PRESSED with cnt=0. first is unchanged, so the repeat timer restarts its current interval.
  - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE, set key_level<=0, pulse key_release, set cnt=0.
  - Else increment cnt.
- Latency:
  - From a raw edge that then stays stable, key_level and key_press (or key_release) are registered and change SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks later.
  - First repeat pulse comes REPEAT_DELAY clocks after key_press; later pulses follow every REPEAT_PERIOD.
- Output exclusivity: key_press, key_release and key_repeat are never high in the same cycle for the same channel. Each is high for exactly 1 cycle per event.
- Boundaries:
  - A glitch shorter than DEBOUNCE_CYCLES samples produces no output change.
  - Counters never wrap; they are cleared on every limit hit or state change.
  - Simultaneous events on several channels are handled independently in the same cycle; any_press ORs them.
  - Reset asserted mid-wait or mid-hold gives no pulse on deassertion unless the input is pressed again for the full debounce time. A key held through reset produces a fresh key_press after SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks.
  - With DEBOUNCE_CYCLES=1, a change is accepted after 1 wait cycle.

Decomposition:
- Shared package key_pkg:
  - typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_t
  - localparam CLK_HZ=27_000_000
  - helper function ms_to_cycles(ms)
- One natural sub-module, key_debounce_channel: synchroniser, FSM and counter for a single key.
- The top level holds a generate loop over N_KEYS, plus any_press.

Test Plan:
(All scenarios use the small test parameters N_KEYS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=0.)
1. Reset: hold rst=1 with key=2'b11 → all outputs 0. Release rst with key held → key_press[0] and key_press[1] pulse exactly 7 clocks later, and any_press=1 in that cycle.
2. Bounce: key[0] toggles 1,0,1,1,0 (one change per clock), then stays 0 → no key_press and key_level[0]=0 throughout.
3. Clean press/hold/release on key[0]:
   - key_press[0] at +7.
   - key_repeat[0] at +17, +20, +23.
   - Drop key[0] at +24 → key_release[0] at +31, key_level[0]=0 from +31.
   - key[1] outputs stay 0 throughout.
4. Release bounce: while PRESSED, key[0] drops for 2 clocks then returns → no key_release. The next key_repeat comes REPEAT_PERIOD clocks after returning to PRESSED.
5. Async reset mid-PRESS_WAIT: assert rst between clock edges at +4 → outputs 0 immediately. Deassert with key low → no pulses for 20 clocks.
6. ACTIVE_LOW=1 rebuild, REPEAT_EN=0: key idles at 2'b11. Driving key[1]=0 gives key_press[1] at +7. key_repeat stays 0 for 50 held clocks.
